osd_cmd_tx: RTL and testbench

OSD_CMD_TX -- requirements
Module: osd_cmd_tx

---
 rtl/osd_pkg.sv | 36 +++
 rtl/osd_cmd_tx.sv | 175 +++++++++++++++++
 tb/tb_osd_cmd_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/osd_pkg.sv
// OSD command encoding shared by the command transmitter and the OSD receiver.
package osd_pkg;

  typedef enum logic [2:0] {
    OP_DISABLE = 3'd0,
    OP_ENABLE  = 3'd1,
    OP_COLOR   = 3'd2,
    OP_SIZE    = 3'd3,
    OP_WRITE   = 3'd4
  } osd_op_e;

  localparam logic [7:0] CB_WRITE   = 8'h20;
  localparam logic [7:0] CB_DISABLE = 8'h40;
  localparam logic [7:0] CB_ENABLE  = 8'h41;
  localparam logic [7:0] CB_COLOR   = 8'h80;
  localparam logic [7:0] CB_SIZE    = 8'hC0;
  localparam int         INFO_SHIFT = 2;
  localparam logic [9:0] MAX_LEN    = 10'd512;
  localparam logic [9:0] INFO_WORDS = 10'd5;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  // a carries the low argument bits; each op uses only its own field
  function automatic logic [7:0] cmd_byte(input osd_op_e op, input logic [5:0] a);
    case (op)
      OP_ENABLE: cmd_byte = CB_ENABLE | ({7'd0, a[0]} << INFO_SHIFT);
      OP_COLOR:  cmd_byte = CB_COLOR  | {2'd0, a};
      OP_SIZE:   cmd_byte = CB_SIZE   | {5'd0, a[2:0]};
      OP_WRITE:  cmd_byte = CB_WRITE  | {3'd0, a[4:0]};
      default:   cmd_byte = CB_DISABLE;
    endcase
  endfunction

endpackage

// File: rtl/osd_cmd_tx.sv
// Serialises OSD commands into io_osd-framed 16-bit words clocked out by io_strobe.
module osd_cmd_tx
  import osd_pkg::*;
#(
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2,
  parameter int GAP       = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  input  logic [9:0]  cmd_len,
  input  logic [11:0] info_x,
  input  logic [11:0] info_y,
  input  logic [5:0]  info_w,
  input  logic [5:0]  info_h,
  input  logic [1:0]  info_rot,
  output logic [8:0]  rd_addr,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy
);

  localparam int MAXC = (STROBE_HI > STROBE_LO) ? ((STROBE_HI > GAP) ? STROBE_HI : GAP)
                                                : ((STROBE_LO > GAP) ? STROBE_LO : GAP);
  localparam int CW = $clog2(MAXC);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STB_HI, S_STB_LO, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [9:0]    word_q, word_d, pay_q, pay_d;
  osd_op_e       op_q, op_d, op_in;
  logic [11:0]   x_q, x_d, y_q, y_d;
  logic [5:0]    w_q, w_d, h_q, h_d;
  logic [1:0]    rot_q, rot_d;
  logic [15:0]   din_q, din_d, pay_word;
  logic          rdy_q, rdy_d;
  logic          accept, more;
  logic          unused_arg;

  assign unused_arg = ^cmd_arg[7:6];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      word_q  <= '0;
      pay_q   <= '0;
      op_q    <= OP_DISABLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      rot_q   <= '0;
      din_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      word_q  <= word_d;
      pay_q   <= pay_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      rot_q   <= rot_d;
      din_q   <= din_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    word_d   = word_q;
    pay_d    = pay_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    rot_d    = rot_q;
    din_d    = din_q;
    op_in    = osd_op_e'(cmd_op);
    accept   = cmd_valid & rdy_q;
    more     = word_q < pay_q;
    // word_q is the word on the wire, so it also indexes the next payload item
    case (word_q[2:0])
      3'd0:    pay_word = {4'd0, x_q};
      3'd1:    pay_word = {4'd0, y_q};
      3'd2:    pay_word = {10'd0, w_q};
      3'd3:    pay_word = {10'd0, h_q};
      default: pay_word = {14'd0, rot_q};
    endcase
    if (op_q == OP_WRITE) pay_word = {8'h00, rd_data};

    case (state_q)
      S_IDLE: begin
        if (accept && op_legal(cmd_op)) begin
          state_d = S_SETUP;
          op_d    = op_in;
          x_d     = info_x;
          y_d     = info_y;
          w_d     = info_w;
          h_d     = info_h;
          rot_d   = info_rot;
          word_d  = '0;
          tcnt_d  = '0;
          din_d   = {8'h00, cmd_byte(op_in, cmd_arg[5:0])};
          case (op_in)
            OP_ENABLE: pay_d = cmd_arg[0] ? INFO_WORDS : 10'd0;
            OP_WRITE:  pay_d = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
            default:   pay_d = 10'd0;
          endcase
        end
      end
      S_SETUP: begin
        state_d = S_STB_HI;
        tcnt_d  = '0;
      end
      S_STB_HI: begin
        if (tcnt_q == CW'(STROBE_HI - 1)) begin
          state_d = S_STB_LO;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_STB_LO: begin
        // next word lands after the first low cycle, when a fetched byte is valid
        if (tcnt_q == '0 && more) din_d = pay_word;
        if (tcnt_q == CW'(STROBE_LO - 1)) begin
          tcnt_d = '0;
          if (more) begin
            state_d = S_STB_HI;
            word_d  = word_q + 10'd1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (tcnt_q == CW'(GAP - 1)) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // an accepted illegal op still costs one not-ready cycle
    rdy_d = (state_d == S_IDLE) && !accept;
  end

  assign cmd_ready = rdy_q;
  assign busy      = state_q != S_IDLE;
  assign io_osd    = (state_q == S_SETUP) || (state_q == S_STB_HI) || (state_q == S_STB_LO);
  assign io_strobe = state_q == S_STB_HI;
  assign io_din    = din_q;
  assign rd_addr   = word_q[8:0];
  assign rd_en     = (state_q == S_STB_HI) && (tcnt_q == CW'(STROBE_HI - 1)) &&
                     (op_q == OP_WRITE) && more;

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Directed bench for osd_cmd_tx at default timing (2/2/2), cycle-accurate frame checks.
module tb_osd_cmd_tx;
  localparam int P    = 4;
  localparam int MAXS = 2200;

  logic        clk_sys = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_arg = '0;
  logic [9:0]  cmd_len = '0;
  logic [11:0] info_x = '0, info_y = '0;
  logic [5:0]  info_w = '0, info_h = '0;
  logic [1:0]  info_rot = '0;
  logic [7:0]  rd_data = '0;
  logic [8:0]  rd_addr;
  logic        rd_en, io_osd, io_strobe, busy, cmd_ready;
  logic [15:0] io_din;

  always #5 clk_sys = ~clk_sys;

  osd_cmd_tx dut (
    .clk_sys(clk_sys), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_len(cmd_len), .info_x(info_x), .info_y(info_y),
    .info_w(info_w), .info_h(info_h), .info_rot(info_rot), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din), .busy(busy)
  );

  logic [7:0] mem [512];
  always @(posedge clk_sys) if (rd_en) rd_data <= mem[rd_addr];

  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // per-cycle samples, index = cycles after the accept cycle
  bit          s_osd[MAXS], s_stb[MAXS], s_ren[MAXS], s_busy[MAXS], s_rdy[MAXS];
  logic [15:0] s_din[MAXS];
  logic [8:0]  s_addr[MAXS];
  int          last_rel, n_s;
  int          n_rise, rise1, osd_n, rd_n, rd1, unstable;
  logic [15:0] words[$], exp_w[$];
  logic [8:0]  addrs[$];

  task automatic issue(input logic [2:0] op, input logic [7:0] arg, input logic [9:0] len);
    int w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk_sys); w++; end
    check("ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_len = len;
  endtask

  task automatic watch(input int maxc, input bit stop_rdy, input bit b2b);
    last_rel = -1;
    n_s = maxc - 1;
    s_stb[0] = 1'b0; s_osd[0] = 1'b0; s_din[0] = io_din;
    for (int r = 1; r < maxc; r++) begin
      @(negedge clk_sys);
      if (r == 1) begin
        if (b2b) begin
          cmd_op = 3'd3; cmd_arg = 8'd2;
        end else begin
          // scramble everything once the command is latched
          cmd_valid = 1'b0; cmd_op = 3'd2; cmd_arg = 8'hFF; cmd_len = 10'd7;
          info_x = 12'hABC; info_y = 12'h123; info_w = 6'h3F; info_h = 6'h2A; info_rot = 2'd3;
        end
      end
      s_osd[r] = io_osd; s_stb[r] = io_strobe; s_din[r] = io_din; s_ren[r] = rd_en;
      s_addr[r] = rd_addr; s_busy[r] = busy; s_rdy[r] = cmd_ready;
      if (stop_rdy && cmd_ready) begin
        last_rel = r; n_s = r;
        break;
      end
    end
  endtask

  task automatic analyze();
    n_rise = 0; rise1 = -1; osd_n = 0; rd_n = 0; rd1 = -1; unstable = 0;
    words.delete(); addrs.delete();
    for (int r = 1; r <= n_s; r++) begin
      if (s_stb[r] && !s_stb[r-1]) begin
        n_rise++;
        if (rise1 < 0) rise1 = r;
        words.push_back(s_din[r]);
        if (s_din[r] !== s_din[r-1]) unstable++;
      end else if (s_stb[r] && s_din[r] !== s_din[r-1]) unstable++;
      if (s_osd[r]) osd_n++;
      if (s_ren[r]) begin
        rd_n++;
        if (rd1 < 0) rd1 = r;
        addrs.push_back(s_addr[r]);
      end
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] arg, input logic [9:0] len, input int maxc);
    issue(op, arg, len);
    watch(maxc, 1'b1, 1'b0);
    analyze();
  endtask

  task automatic chk_frame(input string tag, input int exp_rdy);
    int bad = 0;
    check({tag, "_nwords"}, n_rise, exp_w.size());
    for (int i = 0; i < exp_w.size() && i < words.size(); i++)
      if (words[i] !== exp_w[i]) begin
        bad++;
        if (bad == 1) check({tag, "_word"}, words[i], exp_w[i]);
      end
    if (bad == 0) check({tag, "_words_ok"}, bad, 0);
    check({tag, "_rise1"}, rise1, 2);
    check({tag, "_osd_len"}, osd_n, 1 + exp_w.size() * P);
    check({tag, "_osd_t1"}, s_osd[1], 1);
    check({tag, "_rdy_rise"}, last_rel, exp_rdy);
    check({tag, "_din_stable"}, unstable, 0);
  endtask

  task automatic chk_outs_zero(input string tag);
    check(tag, {cmd_ready, io_osd, io_strobe, io_din, rd_en, rd_addr, busy}, 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'((i * 37 + 11) & 255);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    #2 chk_outs_zero("reset_outs");
    @(negedge clk_sys) reset = 1'b0;
    #1 check("rdy_in_release", cmd_ready, 0);
    @(posedge clk_sys) #1 check("rdy_first_edge", cmd_ready, 1);
    @(negedge clk_sys);

    // DISABLE
    run(3'd0, 8'h00, 10'd0, 40);
    exp_w = '{16'h0040};
    chk_frame("disable", 8);
    check("disable_rd", rd_n, 0);

    // COLOR rgb=0x2A
    run(3'd2, 8'h2A, 10'd0, 40);
    exp_w = '{16'h00AA};
    chk_frame("color", 8);
    check("color_rd", rd_n, 0);

    // ENABLE with info box
    info_x = 12'd100; info_y = 12'd40; info_w = 6'd5; info_h = 6'd4; info_rot = 2'd1;
    run(3'd1, 8'h01, 10'd0, 60);
    exp_w = '{16'h0045, 16'h0064, 16'h0028, 16'h0005, 16'h0004, 16'h0001};
    chk_frame("enable", 28);

    // ENABLE without info: command byte only
    run(3'd1, 8'h00, 10'd0, 40);
    exp_w = '{16'h0041};
    chk_frame("enable0", 8);

    // WRITE line 3, 4 bytes
    run(3'd4, 8'h03, 10'd4, 60);
    exp_w = '{16'h0023, 16'h0011, 16'h0022, 16'h0033, 16'h0044};
    chk_frame("write", 24);
    check("write_rd_n", rd_n, 4);
    check("write_rd_t", rd1, 3);
    for (int j = 0; j < addrs.size(); j++) check("write_rd_addr", addrs[j], j);

    // WRITE len 0
    run(3'd4, 8'h00, 10'd0, 40);
    exp_w = '{16'h0020};
    chk_frame("write0", 8);
    check("write0_rd", rd_n, 0);

    // WRITE len 1000 clamps to 512 bytes
    run(3'd4, 8'h1F, 10'd1000, MAXS);
    exp_w = '{16'h003F};
    for (int j = 0; j < 512; j++) exp_w.push_back({8'h00, mem[j]});
    chk_frame("clamp", 2 + 513 * P + 2);
    check("clamp_rd_n", rd_n, 512);
    if (addrs.size() > 0) check("clamp_last_addr", addrs[addrs.size()-1], 511);

    // illegal op: dropped, ready low for one cycle
    run(3'd5, 8'h00, 10'd0, 20);
    check("illegal_rdy", last_rel, 2);
    check("illegal_rdy_t1", s_rdy[1], 0);
    check("illegal_osd", osd_n, 0);
    check("illegal_busy", s_busy[1], 0);

    // reset in the middle of WRITE payload word 2
    issue(3'd4, 8'h03, 10'd4);
    watch(11, 1'b0, 1'b0);
    check("mid_stb_w2", s_stb[10], 1);
    #2 reset = 1'b1;
    #1 chk_outs_zero("mid_reset_outs");
    @(negedge clk_sys) reset = 1'b0;
    #1 check("mid_rdy_release", cmd_ready, 0);
    @(posedge clk_sys) #1 check("mid_rdy_edge", cmd_ready, 1);
    check("mid_no_resume", {io_osd, busy}, 0);
    @(negedge clk_sys);
    run(3'd0, 8'h00, 10'd0, 40);
    exp_w = '{16'h0040};
    chk_frame("post_rst", 8);

    // cmd_valid held: DISABLE then SIZE 2
    issue(3'd0, 8'h00, 10'd0);
    watch(20, 1'b0, 1'b1);
    cmd_valid = 1'b0;
    check("b2b_w0", s_din[2], 16'h0040);
    begin
      int gapc = 0;
      // GAP-state cycles; the IDLE accept cycle at rel 8 follows them
      for (int r = 6; r <= 8; r++) if (!s_osd[r] && s_busy[r]) gapc++;
      check("b2b_gap", gapc, 2);
    end
    check("b2b_fall", s_osd[6], 0);
    check("b2b_restart", {s_osd[8], s_osd[9]}, 2'b01);
    check("b2b_rise2", {s_stb[9], s_stb[10]}, 2'b01);
    check("b2b_w1", s_din[10], 16'h00C2);

    begin
      int w = 0;
      while (busy && w < 100) begin @(negedge clk_sys); w++; end
      check("final_idle", busy, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
